// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage RISC-V pipeline.
//   - E-stage operand forwarding. M has priority over W, and x0 is never forwarded.
//   - Load-use stall detection in Decode.
//   - Branch/jump flush of D and E.
//   - Multi-cycle execute (MUL/DIV) stall FSM with an MD_LAT-cycle E occupancy.
//   - Saturating stall-cycle performance counter.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   Rs1D/Rs2D, Rs1E/Rs2E    source registers in D and E
//   RdE/RdM/RdW             destination registers in E/M/W
//   RegWriteM/RegWriteW     register write enables in M/W
//   ResultSrcE0             E-stage instruction is a load
//   PCSrcE                  non-zero: taken branch/jump resolved in E
//   MdStartE                first cycle of a multi-cycle op in E
//   ForwardAE/ForwardBE     operand mux selects (00 regfile, 01 W, 10 M)
//   StallF/StallD/StallE    pipeline register holds
//   FlushD/FlushE/FlushM    pipeline register clears
//   MdBusy                  FSM is in MD_RUN
//   StallCnt                stalled cycles since reset (saturating)
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic [1:0]        PCSrcE,
  input  logic              MdStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MdBusy,
  output logic [CNT_W-1:0]  StallCnt
);

  localparam int CW       = $clog2(MD_LAT) + 1;
  localparam bit MD_MULTI = (MD_LAT > 1);

  typedef enum logic {
    IDLE,
    MD_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              md_busy_q, md_busy_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              md_stall;
  logic              lw_stall;
  logic              branch;
  logic              stall_any;
  logic [1:0]        fwd_a, fwd_b;

  // Forwarding select.
  always_comb begin
    fwd_a = 2'b00;
    if (RegWriteM && (Rs1E == RdM) && (Rs1E != '0))      fwd_a = 2'b10;
    else if (RegWriteW && (Rs1E == RdW) && (Rs1E != '0)) fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (RegWriteM && (Rs2E == RdM) && (Rs2E != '0))      fwd_b = 2'b10;
    else if (RegWriteW && (Rs2E == RdW) && (Rs2E != '0)) fwd_b = 2'b01;
  end

  // Multi-cycle FSM next state. The counter is loaded with MD_LAT-1 on entry.
  // On the cnt==1 cycle E is released, so the stall window is MD_LAT-1 cycles long.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (MdStartE && MD_MULTI) begin
          state_d = MD_RUN;
          cnt_d   = CW'(MD_LAT - 1);
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    md_busy_d = (state_d == MD_RUN);
  end

  // Stall, flush and counter logic.
  always_comb begin
    md_stall  = ((state_q == IDLE) && MdStartE && MD_MULTI) ||
                ((state_q == MD_RUN) && (cnt_q > CW'(1)));
    lw_stall  = ResultSrcE0 && (RdE != '0) &&
                ((Rs1D == RdE) || (Rs2D == RdE)) && !md_busy_q;
    branch    = (PCSrcE != 2'b00);
    stall_any = md_stall || lw_stall;

    stall_cnt_d = stall_cnt_q;
    if (stall_any && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      md_busy_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_busy_q   <= md_busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // The combinational outputs are gated by rst_n so that they read 0 while
  // reset is held. They drop asynchronously when reset is asserted mid-run.
  // During a multi-cycle stall the held E instruction is never flushed.
  always_comb begin
    ForwardAE = rst_n ? fwd_a : 2'b00;
    ForwardBE = rst_n ? fwd_b : 2'b00;
    StallF    = rst_n && stall_any;
    StallD    = rst_n && stall_any;
    StallE    = rst_n && md_stall;
    FlushM    = rst_n && md_stall;
    FlushD    = rst_n && !md_stall && branch;
    FlushE    = rst_n && !md_stall && (lw_stall || branch);
    MdBusy    = md_busy_q;
    StallCnt  = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl.
// Two instances share the same stimulus:
//   u_dut   uses the default parameters (MD_LAT=4, CNT_W=16).
//   u_dut_b uses MD_LAT=1 and CNT_W=4, to cover the no-stall case and counter saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, MdStartE;
  logic [1:0] PCSrcE;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy;
  logic [15:0] StallCnt;

  logic [1:0]  ForwardAE_b, ForwardBE_b;
  logic        StallF_b, StallD_b, StallE_b, FlushD_b, FlushE_b, FlushM_b, MdBusy_b;
  logic [3:0]  StallCnt_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .MD_LAT(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MdBusy(MdBusy), .StallCnt(StallCnt)
  );

  hazard_ctrl #(.REG_AW(5), .MD_LAT(1), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .ForwardAE(ForwardAE_b), .ForwardBE(ForwardBE_b),
    .StallF(StallF_b), .StallD(StallD_b), .StallE(StallE_b),
    .FlushD(FlushD_b), .FlushE(FlushE_b), .FlushM(FlushM_b),
    .MdBusy(MdBusy_b), .StallCnt(StallCnt_b)
  );

  // A multi-cycle op and a taken branch can never be the same E instruction.
  always @(negedge clk)
    if (rst_n) assert (!(MdStartE && (PCSrcE != 2'b00)))
      else $error("illegal MdStartE with PCSrcE");

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0;
    PCSrcE = 2'b00; MdStartE = 1'b0;
  endtask

  // Drive just after the rising edge, and check at the falling edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Expected values for the multi-cycle sequence, one entry per cycle.
  // A load hazard is applied during cycles 1-2.
  logic md_start_v [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic md_load_v  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic exp_stl_a  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic exp_bsy_a  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic exp_stl_b  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    // A forwarding hit is present while reset is held; it must not show on the outputs.
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; MdStartE = 1'b1;
    #3;
    check_eq("rst_fwdA",   32'(ForwardAE), 0);
    check_eq("rst_stallF", 32'(StallF), 0);
    check_eq("rst_stallE", 32'(StallE), 0);
    check_eq("rst_flushM", 32'(FlushM), 0);
    check_eq("rst_busy",   32'(MdBusy), 0);
    check_eq("rst_cnt",    32'(StallCnt), 0);
    MdStartE = 1'b0;
    mid(); rst_n = 1'b1;

    // Forwarding.
    tick(); clear_inputs();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
    Rs2E = 5'd9;
    mid();
    check_eq("fwdA_M", 32'(ForwardAE), 2);
    check_eq("fwdB_none", 32'(ForwardBE), 0);
    tick(); RegWriteM = 1'b0; Rs2E = 5'd5;
    mid();
    check_eq("fwdA_W", 32'(ForwardAE), 1);
    check_eq("fwdB_W", 32'(ForwardBE), 1);
    tick(); Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1; Rs2E = 5'd0;
    mid();
    check_eq("fwdA_x0", 32'(ForwardAE), 0);
    check_eq("fwdB_x0", 32'(ForwardBE), 0);
    check_eq("fwd_nostall", 32'(StallF), 0);

    // Load-use hazard.
    tick(); clear_inputs();
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd3;
    mid();
    check_eq("lw_stallF", 32'(StallF), 1);
    check_eq("lw_stallD", 32'(StallD), 1);
    check_eq("lw_stallE", 32'(StallE), 0);
    check_eq("lw_flushE", 32'(FlushE), 1);
    check_eq("lw_flushD", 32'(FlushD), 0);
    check_eq("lw_flushM", 32'(FlushM), 0);
    check_eq("lw_cnt0", 32'(StallCnt), 0);
    tick(); RdE = 5'd0; Rs2D = 5'd0; Rs1D = 5'd0;
    mid();
    check_eq("lw_cnt1", 32'(StallCnt), 1);
    check_eq("lw_rd0_stallF", 32'(StallF), 0);
    check_eq("lw_rd0_flushE", 32'(FlushE), 0);

    // Branch.
    tick(); clear_inputs(); PCSrcE = 2'b01;
    mid();
    check_eq("br_flushD", 32'(FlushD), 1);
    check_eq("br_flushE", 32'(FlushE), 1);
    check_eq("br_stallF", 32'(StallF), 0);
    check_eq("br_stallE", 32'(StallE), 0);
    tick(); clear_inputs();
    mid();
    check_eq("br_cnt", 32'(StallCnt), 1);

    // Multi-cycle op, with a load hazard presented during MD_RUN.
    for (int c = 0; c < 5; c++) begin
      tick(); clear_inputs();
      MdStartE = md_start_v[c];
      if (md_load_v[c]) begin
        ResultSrcE0 = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
      end
      mid();
      check_eq($sformatf("md%0d_stallF", c), 32'(StallF), 32'(exp_stl_a[c]));
      check_eq($sformatf("md%0d_stallD", c), 32'(StallD), 32'(exp_stl_a[c]));
      check_eq($sformatf("md%0d_stallE", c), 32'(StallE), 32'(exp_stl_a[c]));
      check_eq($sformatf("md%0d_flushM", c), 32'(FlushM), 32'(exp_stl_a[c]));
      check_eq($sformatf("md%0d_flushE", c), 32'(FlushE), 0);
      check_eq($sformatf("md%0d_busy", c),   32'(MdBusy), 32'(exp_bsy_a[c]));
      check_eq($sformatf("md%0d_b_stallE", c), 32'(StallE_b), 0);
      check_eq($sformatf("md%0d_b_stallF", c), 32'(StallF_b), 32'(exp_stl_b[c]));
      check_eq($sformatf("md%0d_b_busy", c),   32'(MdBusy_b), 0);
    end
    check_eq("md_cnt_a", 32'(StallCnt), 4);
    check_eq("md_cnt_b", 32'(StallCnt_b), 3);

    // Asynchronous reset asserted during the second MD_RUN cycle.
    tick(); clear_inputs(); MdStartE = 1'b1;
    tick(); MdStartE = 1'b0;
    tick(); Rs1E = 5'd6; RdM = 5'd6; RegWriteM = 1'b1;
    #1;
    check_eq("ar_pre_stallF", 32'(StallF), 1);
    check_eq("ar_pre_busy", 32'(MdBusy), 1);
    rst_n = 1'b0;
    #1;
    check_eq("ar_stallF", 32'(StallF), 0);
    check_eq("ar_stallE", 32'(StallE), 0);
    check_eq("ar_flushM", 32'(FlushM), 0);
    check_eq("ar_fwdA",   32'(ForwardAE), 0);
    check_eq("ar_busy",   32'(MdBusy), 0);
    check_eq("ar_cnt",    32'(StallCnt), 0);
    mid(); rst_n = 1'b1;
    tick(); clear_inputs();
    mid();
    check_eq("ar_idle_stallF", 32'(StallF), 0);
    check_eq("ar_idle_busy", 32'(MdBusy), 0);
    check_eq("ar_cnt_b", 32'(StallCnt_b), 0);

    // Saturation of the 4-bit counter under a continuous load-use stall.
    for (int n = 1; n <= 21; n++) begin
      tick();
      if (n == 1) begin
        ResultSrcE0 = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
      end
      mid();
      if (n == 15) check_eq("sat_b_14", 32'(StallCnt_b), 14);
      if (n == 16) check_eq("sat_b_15", 32'(StallCnt_b), 15);
      if (n == 17) check_eq("sat_b_hold", 32'(StallCnt_b), 15);
      if (n == 21) begin
        check_eq("sat_b_end", 32'(StallCnt_b), 15);
        check_eq("sat_a_end", 32'(StallCnt), 20);
      end
    end
    tick(); clear_inputs();
    tick();
    mid();
    check_eq("sat_b_after", 32'(StallCnt_b), 15);
    check_eq("sat_a_after", 32'(StallCnt), 21);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
